// File: rtl/fetch_pc_unit.sv
// Front-end PC sequencer: issues aligned 64-bit imem fetches, queues
// in-order returns for decode, and handles branch redirects with drain.
module fetch_pc_unit #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int          FIFO_DEPTH = 4,
  parameter int          MAX_OUT    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        do_jump,
  input  logic [63:0] jump_pc,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [63:0] imem_rdata,
  output logic        inst_valid,
  output logic [63:0] inst,
  output logic [63:0] inst_pc,
  input  logic        decode_ready,
  input  logic        stall
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [63:0] BOOT_PC = RESET_PC & ~64'h7;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    DRAIN
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [63:0]   r_fetch_pc;
  logic [63:0]   r_ret_pc;
  logic [63:0]   r_tag_pc;
  logic          r_first;

  logic [CW-1:0] r_out;
  logic [CW-1:0] w_out_nxt;
  logic [CW-1:0] r_cnt;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;

  logic [63:0]   r_data [FIFO_DEPTH];
  logic [63:0]   r_pc   [FIFO_DEPTH];

  logic          w_issue;
  logic          w_fire;
  logic          w_push;
  logic          w_pop;
  logic [CW:0]   w_inflight;
  logic [63:0]   w_push_pc;
  logic [CW-1:0] w_inc;
  logic [CW-1:0] w_dec;
  logic [CW-1:0] w_psh;
  logic [CW-1:0] w_pp;

  // Words already queued plus words in flight must fit in the FIFO.
  assign w_inflight = {1'b0, r_cnt} + {1'b0, r_out};
  assign w_issue    = (r_state == RUN)
                   && (r_out < CW'(MAX_OUT))
                   && (w_inflight < (CW+1)'(FIFO_DEPTH));

  assign imem_req   = w_issue;
  assign imem_addr  = r_fetch_pc;

  assign w_fire     = w_issue & imem_gnt;
  assign w_push     = imem_rvalid & (r_state == RUN) & ~do_jump;
  assign inst_valid = (r_cnt != '0);
  assign w_pop      = inst_valid & decode_ready & ~stall & ~do_jump;

  assign inst       = r_data[r_rptr];
  assign inst_pc    = r_pc[r_rptr];
  assign w_push_pc  = r_first ? r_tag_pc : r_ret_pc;

  assign w_inc      = {{(CW-1){1'b0}}, w_fire};
  assign w_dec      = {{(CW-1){1'b0}}, imem_rvalid};
  assign w_psh      = {{(CW-1){1'b0}}, w_push};
  assign w_pp       = {{(CW-1){1'b0}}, w_pop};

  always_comb begin
    w_out_nxt = r_out + w_inc - w_dec;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (do_jump) begin
      w_state_nxt = (w_out_nxt != '0) ? DRAIN : RUN;
    end else begin
      unique case (r_state)
        BOOT:    w_state_nxt = RUN;
        RUN:     w_state_nxt = RUN;
        DRAIN: begin
          if (w_out_nxt == '0) w_state_nxt = RUN;
        end
        default: w_state_nxt = BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= BOOT;
      r_out   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_out   <= w_out_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= BOOT_PC;
    end else if (do_jump) begin
      r_fetch_pc <= {jump_pc[63:3], 3'b000};
    end else if (w_fire) begin
      r_fetch_pc <= r_fetch_pc + 64'd8;
    end
  end

  // First word after a redirect carries the unaligned target PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ret_pc <= BOOT_PC;
      r_tag_pc <= BOOT_PC;
      r_first  <= 1'b0;
    end else if (do_jump) begin
      r_ret_pc <= {jump_pc[63:3], 3'b000};
      r_tag_pc <= {jump_pc[63:1], 1'b0};
      r_first  <= 1'b1;
    end else if (w_push) begin
      r_ret_pc <= r_ret_pc + 64'd8;
      r_first  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_data[i] <= '0;
        r_pc[i]   <= '0;
      end
    end else if (do_jump) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) begin
        r_data[r_wptr] <= imem_rdata;
        r_pc[r_wptr]   <= w_push_pc;
        r_wptr         <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      r_cnt <= r_cnt + w_psh - w_pp;
    end
  end

  ap_no_orphan_rvalid: assert property (
    @(posedge clk) disable iff (!rst_n)
    imem_rvalid |-> (r_out != '0)
  );

  ap_no_overflow: assert property (
    @(posedge clk) disable iff (!rst_n)
    w_push |-> (r_cnt < CW'(FIFO_DEPTH))
  );

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit with a fixed 2-cycle imem model.
// Pops are checked against an expected PC stream as they happen.
module tb_fetch_pc_unit;

  localparam logic [63:0] K = 64'hA5A5_0F0F_5A5A_F0F0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        do_jump = 1'b0;
  logic [63:0] jump_pc = '0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [63:0] imem_rdata;
  logic        inst_valid;
  logic [63:0] inst;
  logic [63:0] inst_pc;
  logic        decode_ready = 1'b1;
  logic        stall = 1'b0;
  logic        gnt_en = 1'b1;

  int          n_vec = 0;
  int          n_mis = 0;
  int          n_pop = 0;
  int          p0;
  logic [63:0] exp_pc = '0;

  logic        p1_v, p2_v;
  logic [63:0] p1_a, p2_a;

  always #5 clk = ~clk;

  fetch_pc_unit #(
    .RESET_PC  (64'h0),
    .FIFO_DEPTH(4),
    .MAX_OUT   (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .do_jump     (do_jump),
    .jump_pc     (jump_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .decode_ready(decode_ready),
    .stall       (stall)
  );

  // imem: grant when enabled, return addr^K two cycles after the grant
  assign imem_gnt    = gnt_en;
  assign imem_rvalid = p2_v;
  assign imem_rdata  = p2_a ^ K;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_v <= 1'b0;
      p2_v <= 1'b0;
      p1_a <= '0;
      p2_a <= '0;
    end else begin
      p1_v <= imem_req & imem_gnt;
      p1_a <= imem_addr;
      p2_v <= p1_v;
      p2_a <= p1_a;
    end
  end

  typedef struct {
    logic        rdy;
    logic        stl;
    logic        req;
    logic [63:0] addr;
    logic        iv;
    logic [63:0] ipc;
  } vec_t;

  vec_t tv [11];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (inst_valid && decode_ready && !stall && !do_jump) begin
      chk("pop_pc", inst_pc, exp_pc);
      chk("pop_data", inst, {exp_pc[63:3], 3'b000} ^ K);
      exp_pc = {exp_pc[63:3], 3'b000} + 64'd8;
      n_pop++;
    end
    if (do_jump) exp_pc = {jump_pc[63:1], 1'b0};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      tick();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    do_jump = 1'b0;
    decode_ready = 1'b1;
    stall = 1'b0;
    gnt_en = 1'b1;
    exp_pc = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic setv(input int i, input logic req, input logic [63:0] a,
                      input logic iv, input logic [63:0] pc);
    tv[i] = '{rdy: 1'b1, stl: 1'b0, req: req, addr: a, iv: iv, ipc: pc};
  endtask

  initial begin
    setv(0,  1'b0, 64'd0,  1'b0, 64'd0);
    setv(1,  1'b1, 64'd0,  1'b0, 64'd0);
    setv(2,  1'b1, 64'd8,  1'b0, 64'd0);
    setv(3,  1'b0, 64'd16, 1'b0, 64'd0);
    setv(4,  1'b1, 64'd16, 1'b1, 64'd0);
    setv(5,  1'b1, 64'd24, 1'b1, 64'd8);
    setv(6,  1'b0, 64'd32, 1'b0, 64'd0);
    setv(7,  1'b1, 64'd32, 1'b1, 64'd16);
    setv(8,  1'b1, 64'd40, 1'b1, 64'd24);
    setv(9,  1'b0, 64'd48, 1'b0, 64'd0);
    setv(10, 1'b1, 64'd48, 1'b1, 64'd32);

    // reset values while held in reset
    #2;
    chk("rst_req", 64'(imem_req), 64'd0);
    chk("rst_addr", imem_addr, 64'd0);
    chk("rst_iv", 64'(inst_valid), 64'd0);
    chk("rst_inst", inst, 64'd0);
    chk("rst_ipc", inst_pc, 64'd0);

    // sequential fetch after reset
    do_reset();
    for (int i = 0; i < 11; i++) begin
      decode_ready = tv[i].rdy;
      stall = tv[i].stl;
      step();
      chk($sformatf("t1_req%0d", i), 64'(imem_req), 64'(tv[i].req));
      chk($sformatf("t1_addr%0d", i), imem_addr, tv[i].addr);
      chk($sformatf("t1_iv%0d", i), 64'(inst_valid), 64'(tv[i].iv));
      if (tv[i].iv) begin
        chk($sformatf("t1_ipc%0d", i), inst_pc, tv[i].ipc);
      end
      tick();
    end

    // decode blocked: FIFO fills to 4, fetch stops
    decode_ready = 1'b0;
    cyc(10);
    step();
    chk("t2_req_full", 64'(imem_req), 64'd0);
    chk("t2_iv_full", 64'(inst_valid), 64'd1);
    tick();
    gnt_en = 1'b0;
    decode_ready = 1'b1;
    p0 = n_pop;
    cyc(8);
    step();
    chk("t2_pops", 64'(n_pop - p0), 64'd4);
    chk("t2_req_resume", 64'(imem_req), 64'd1);
    chk("t2_addr_a", imem_addr, exp_pc);
    tick();
    step();
    chk("t2_addr_hold", imem_addr, exp_pc);
    tick();
    gnt_en = 1'b1;
    p0 = n_pop;
    cyc(12);
    chk("t2_more_pops", 64'(n_pop - p0 >= 4), 64'd1);

    // redirect with two outstanding
    do_reset();
    cyc(2);
    do_jump = 1'b1;
    jump_pc = 64'h1002;
    cyc(1);
    do_jump = 1'b0;
    step();
    chk("t3_req_c3", 64'(imem_req), 64'd0);
    chk("t3_iv_c3", 64'(inst_valid), 64'd0);
    tick();
    step();
    chk("t3_req_c4", 64'(imem_req), 64'd0);
    tick();
    step();
    chk("t3_req_c5", 64'(imem_req), 64'd1);
    chk("t3_addr_c5", imem_addr, 64'h1000);
    tick();
    p0 = n_pop;
    cyc(10);
    chk("t3_pops", 64'(n_pop - p0 >= 2), 64'd1);

    // redirect in the same cycle as a grant and a return
    do_reset();
    cyc(4);
    do_jump = 1'b1;
    jump_pc = 64'h4000;
    step();
    chk("t4_req_c4", 64'(imem_req), 64'd1);
    chk("t4_rv_c4", 64'(imem_rvalid), 64'd1);
    tick();
    do_jump = 1'b0;
    step();
    chk("t4_iv_c5", 64'(inst_valid), 64'd0);
    chk("t4_req_c5", 64'(imem_req), 64'd0);
    tick();
    step();
    chk("t4_req_c6", 64'(imem_req), 64'd0);
    tick();
    step();
    chk("t4_req_c7", 64'(imem_req), 64'd1);
    chk("t4_addr_c7", imem_addr, 64'h4000);
    chk("t4_iv_c7", 64'(inst_valid), 64'd0);
    tick();
    p0 = n_pop;
    cyc(8);
    chk("t4_pops", 64'(n_pop - p0 >= 2), 64'd1);

    // two redirects while draining
    do_reset();
    cyc(2);
    do_jump = 1'b1;
    jump_pc = 64'h2000;
    cyc(1);
    jump_pc = 64'h3000;
    cyc(1);
    do_jump = 1'b0;
    step();
    chk("t5_req_c4", 64'(imem_req), 64'd0);
    tick();
    step();
    chk("t5_req_c5", 64'(imem_req), 64'd1);
    chk("t5_addr_c5", imem_addr, 64'h3000);
    tick();
    p0 = n_pop;
    cyc(8);
    chk("t5_pops", 64'(n_pop - p0 >= 2), 64'd1);

    // address wrap, then reset with words queued and in flight
    do_reset();
    do_jump = 1'b1;
    jump_pc = 64'hFFFF_FFFF_FFFF_FFF8;
    cyc(1);
    do_jump = 1'b0;
    step();
    chk("t6_addr_top", imem_addr, 64'hFFFF_FFFF_FFFF_FFF8);
    tick();
    step();
    chk("t6_addr_wrap", imem_addr, 64'h0);
    chk("t6_req_wrap", 64'(imem_req), 64'd1);
    tick();
    p0 = n_pop;
    cyc(2);
    chk("t6_pop_top", 64'(n_pop - p0), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_req", 64'(imem_req), 64'd0);
    chk("t6_rst_addr", imem_addr, 64'd0);
    chk("t6_rst_iv", 64'(inst_valid), 64'd0);
    chk("t6_rst_inst", inst, 64'd0);
    chk("t6_rst_ipc", inst_pc, 64'd0);
    do_reset();
    step();
    chk("t6_boot_req", 64'(imem_req), 64'd0);
    tick();
    p0 = n_pop;
    cyc(8);
    chk("t6_after_pops", 64'(n_pop - p0 >= 2), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
